// File: rtl/dmem_pkg.sv
// Package: dmem_pkg
// Shared types and constants for the data memory responder.
//   state_e   : responder FSM state (IDLE, WAIT, RESP)
//   F3_*      : RV32I load/store width codes carried on req_funct3
//   lane_mask : byte lanes touched by an access of a given width code
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Stores only know SB/SH/SW, so the unsigned load codes fall into the
  // word case when we=1. Unknown codes are treated as word accesses.
  function automatic logic [3:0] lane_mask(input logic [2:0] funct3, input logic we);
    logic [3:0] m;
    m = 4'b1111;
    if (we) begin
      if (funct3 == F3_B)      m = 4'b0001;
      else if (funct3 == F3_H) m = 4'b0011;
    end else begin
      case (funct3)
        F3_B, F3_BU: m = 4'b0001;
        F3_H, F3_HU: m = 4'b0011;
        default:     m = 4'b1111;
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Module: load_extend
// Combinational load formatter: takes the raw little-endian word read from
// the byte array (byte 0 = addressed byte) and sign/zero-extends it
// according to the RV32I load width code.
// Ports:
//   raw_word in  32  bytes at addr+0..addr+3, byte 0 in bits [7:0]
//   funct3   in  3   load width/sign code
//   rdata    out 32  extended load result
module load_extend
  import dmem_pkg::*;
(
  input  logic [31:0] raw_word,
  input  logic [2:0]  funct3,
  output logic [31:0] rdata
);

  always_comb begin
    rdata = raw_word;
    case (funct3)
      F3_B:    rdata = {{24{raw_word[7]}}, raw_word[7:0]};
      F3_H:    rdata = {{16{raw_word[15]}}, raw_word[15:0]};
      F3_BU:   rdata = {24'd0, raw_word[7:0]};
      F3_HU:   rdata = {16'd0, raw_word[15:0]};
      default: rdata = raw_word;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Module: data_mem_responder
// Memory-side responder for the core's load/store port. Accepts one request
// at a time, waits WAIT_STATES cycles, performs a byte/half/word access on a
// little-endian byte array (addresses wrap modulo 2**ADDR_WIDTH) and returns
// load data or a store acknowledge on the response channel.
// Optional feature macro: MISALIGN_ERR_EN -- misaligned half/word accesses
// skip the array and respond with rsp_err=1, rsp_rdata=0.
// Ports:
//   clk        in   1   clock, rising edge
//   rst        in   1   asynchronous active-low reset
//   req_valid  in   1   request present
//   req_ready  out  1   high in IDLE
//   req_addr   in   32  byte address (bits above ADDR_WIDTH ignored)
//   req_we     in   1   1 = store, 0 = load
//   req_funct3 in   3   RV32I width/sign code
//   req_wdata  in   32  store data, right-aligned
//   rsp_valid  out  1   response present (RESP state)
//   rsp_ready  in   1   consumer accepts response
//   rsp_rdata  out  32  extended load data, 0 for stores/errors
//   rsp_err    out  1   misaligned access error (0 without the macro)
//   busy       out  1   high in WAIT or RESP
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [31:0]           req_addr,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int CNT_W  = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_STATES);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    we_q, we_d;
  logic [2:0]              f3_q, f3_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

  logic [7:0]              mem [2**ADDR_WIDTH];

  logic                    accept;
  logic                    acc_en;
  logic [ADDR_WIDTH-1:0]   acc_addr;
  logic                    acc_we;
  logic [2:0]              acc_f3;
  logic [DATA_WIDTH-1:0]   acc_wdata;
  logic [3:0]              acc_mask;
  logic                    misalign;
  logic [ADDR_WIDTH-1:0]   lane_idx [NBYTES];
  logic [NBYTES-1:0]       lane_we;
  logic [DATA_WIDTH-1:0]   raw_word;
  logic [DATA_WIDTH-1:0]   ext_data;

  wire unused_addr_hi = ^req_addr[31:ADDR_WIDTH];

  assign accept = (state_q == IDLE) && req_valid;

  // With zero wait states the access happens on the accept edge, so the
  // access operands come straight from the request port while in IDLE.
  assign acc_addr  = (state_q == IDLE) ? req_addr[ADDR_WIDTH-1:0] : addr_q;
  assign acc_we    = (state_q == IDLE) ? req_we     : we_q;
  assign acc_f3    = (state_q == IDLE) ? req_funct3 : f3_q;
  assign acc_wdata = (state_q == IDLE) ? req_wdata  : wdata_q;

  // The counter is loaded with WAIT_STATES and the access fires on the edge
  // that takes it to zero, giving exactly WAIT_STATES cycles in WAIT and an
  // accept-to-rsp_valid latency of WAIT_STATES+1.
  assign acc_en = ((state_q == WAIT) && (cnt_q <= CNT_W'(1))) ||
                  ((WAIT_STATES == 0) && accept);

  assign acc_mask = lane_mask(acc_f3, acc_we);

`ifdef MISALIGN_ERR_EN
  assign misalign = ((acc_mask == 4'b0011) && acc_addr[0]) ||
                    ((acc_mask == 4'b1111) && (acc_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NBYTES; gi++) begin : g_lane
      // Index arithmetic is ADDR_WIDTH wide, so accesses wrap at the top.
      assign lane_idx[gi]         = acc_addr + ADDR_WIDTH'(gi);
      assign raw_word[8*gi +: 8]  = mem[lane_idx[gi]];
      assign lane_we[gi]          = acc_en && acc_we && acc_mask[gi] && !misalign;
    end
  endgenerate

  load_extend u_load_extend (
    .raw_word (raw_word),
    .funct3   (acc_f3),
    .rdata    (ext_data)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    f3_d    = f3_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d  = req_addr[ADDR_WIDTH-1:0];
          we_d    = req_we;
          f3_d    = req_funct3;
          wdata_d = req_wdata;
          cnt_d   = CNT_INIT;
          state_d = (WAIT_STATES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (acc_en) state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (acc_en) rdata_d = (acc_we || misalign) ? '0 : ext_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Array is never reset; rst gating keeps a store from committing while
  // reset is asserted.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NBYTES; i++) begin
      if (rst && lane_we[i]) mem[lane_idx[i]] <= acc_wdata[8*i +: 8];
    end
  end

`ifdef MISALIGN_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (acc_en) err_d = misalign;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_d;
  end

  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);
  assign rsp_rdata = rdata_q;

endmodule
